// File: rtl/bitwise_logic_pkg.sv
// rtl/bitwise_logic_pkg.sv - op-code encodings shared by the bitwise logic pipe
package bitwise_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
  localparam logic [OP_W-1:0] OP_ORN  = 3'd7;

endpackage

// File: rtl/bitwise_op_core.sv
// rtl/bitwise_op_core.sv - combinational eight-way bitwise operator
module bitwise_op_core
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - two-stage streaming bitwise engine with packet accumulate
module bitwise_logic_pipe
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_accum,
  input  logic             in_last,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] s1_a;
  logic [OP_W-1:0]  s1_op;
  logic             s1_accum;
  logic             s1_last;

  logic             acc_open;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] in_res;
  logic [WIDTH-1:0] acc_res;
  logic [WIDTH-1:0] fold_v;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] s2_d;
  logic [CNT_W-1:0] s2_beats;
  logic             in_fire;
  logic             out_fire;
  logic             s1_adv;
  logic             load_s2;

  bitwise_op_core #(.WIDTH(WIDTH)) u_in_core (
    .a  (data_operandA),
    .b  (data_operandB),
    .op (in_op),
    .y  (in_res)
  );

  bitwise_op_core #(.WIDTH(WIDTH)) u_acc_core (
    .a  (acc),
    .b  (s1_a),
    .op (s1_op),
    .y  (acc_res)
  );

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // S1 is consumed even when an open accumulate beat only updates acc
  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign load_s2  = s1_adv && (!s1_accum || s1_last);

  assign fold_v   = acc_open ? acc_res : s1_a;
  assign cnt_next = (count == CNT_MAX) ? count : count + CNT_ONE;
  assign s2_d     = s1_accum ? fold_v : s1_res;
  assign s2_beats = s1_accum ? cnt_next : CNT_ONE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_a     <= '0;
      s1_op    <= OP_AND;
      s1_accum <= 1'b0;
      s1_last  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_res   <= in_res;
      s1_a     <= data_operandA;
      s1_op    <= in_op;
      s1_accum <= in_accum;
      s1_last  <= in_last;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_open <= 1'b0;
      acc      <= '0;
      count    <= '0;
    end else if (s1_adv && s1_accum) begin
      if (s1_last) begin
        acc_open <= 1'b0;
        count    <= '0;
      end else begin
        acc      <= fold_v;
        acc_open <= 1'b1;
        count    <= cnt_next;
      end
    end
  end

  // Flags are registered from the same value as data_result so they never skew
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      data_result <= '0;
      out_zero    <= 1'b1;
      out_ones    <= 1'b0;
      out_parity  <= 1'b0;
      out_beats   <= '0;
    end else if (load_s2) begin
      out_valid   <= 1'b1;
      data_result <= s2_d;
      out_zero    <= (s2_d == '0);
      out_ones    <= (s2_d == '1);
      out_parity  <= ^s2_d;
      out_beats   <= s2_beats;
    end else if (out_fire) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - self-checking bench for bitwise_logic_pipe
module tb_bitwise_logic_pipe;

  localparam int W    = 32;
  localparam int C    = 8;
  localparam int CMAX = (1 << C) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          in_valid, in_ready, in_accum, in_last, out_valid, out_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  data_operandA, data_operandB, data_result;
  logic          out_zero, out_ones, out_parity;
  logic [C-1:0]  out_beats;

  logic          s_in_valid, s_in_ready, s_in_accum, s_in_last, s_out_valid, s_out_ready;
  logic [2:0]    s_in_op;
  logic [7:0]    s_a, s_b, s_result;
  logic          s_zero, s_ones, s_parity;
  logic [1:0]    s_beats;

  bitwise_logic_pipe #(.WIDTH(W), .CNT_W(C)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_accum(in_accum), .in_last(in_last),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .out_valid(out_valid), .out_ready(out_ready), .data_result(data_result),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity), .out_beats(out_beats)
  );

  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(s_in_op), .in_accum(s_in_accum), .in_last(s_in_last),
    .data_operandA(s_a), .data_operandB(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .data_result(s_result),
    .out_zero(s_zero), .out_ones(s_ones), .out_parity(s_parity), .out_beats(s_beats)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: results are what the op table says, packets fold left over A
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return ~(x & y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x | ~y;
    endcase
  endfunction

  logic [W-1:0] m_acc;
  bit           m_open = 0;
  int           m_cnt = 0;
  logic [W-1:0] exp_d[$];
  int           exp_n[$];
  logic [W-1:0] got_d[$];
  int           got_b[$];
  logic         got_z[$];
  logic         got_p[$];

  task automatic model_accept(input logic [2:0] op, input logic acc, input logic last,
                              input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] v;
    if (!acc) begin
      exp_d.push_back(ref_op(op, a, b));
      exp_n.push_back(1);
    end else begin
      v = m_open ? ref_op(op, m_acc, a) : a;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (last) begin
        exp_d.push_back(v);
        exp_n.push_back(m_cnt);
        m_open = 0;
        m_cnt = 0;
      end else begin
        m_acc = v;
        m_open = 1;
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_d.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL unexpected_output: got %0h expected none", data_result);
      end else begin
        logic [W-1:0] ed;
        int en;
        ed = exp_d.pop_front();
        en = exp_n.pop_front();
        chk("result", 64'(data_result), 64'(ed));
        chk("beats", 64'(out_beats), 64'(en));
        chk("flags", 64'({out_zero, out_ones, out_parity}), 64'({ed == '0, ed == '1, ^ed}));
        got_d.push_back(data_result);
        got_b.push_back(int'(out_beats));
        got_z.push_back(out_zero);
        got_p.push_back(out_parity);
      end
    end
  end

  int           s_cnt = 0;
  logic [7:0]   s_got;
  logic [1:0]   s_got_b;
  logic [2:0]   s_got_f;
  always @(negedge clock) begin
    if (reset_n && s_out_valid && s_out_ready) begin
      s_cnt++;
      s_got   = s_result;
      s_got_b = s_beats;
      s_got_f = {s_zero, s_ones, s_parity};
    end
  end

  task automatic send(input logic [2:0] op, input logic acc, input logic last,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 0;
    in_valid = 1; in_op = op; in_accum = acc; in_last = last;
    data_operandA = a; data_operandB = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
    end
    if (ok) model_accept(op, acc, last, a, b);
    else begin
      vec++; bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    #1 in_valid = 0;
  endtask

  task automatic send_s(input logic last, input logic [7:0] a);
    bit ok;
    ok = 0;
    s_in_valid = 1; s_in_op = 3'd0; s_in_accum = 1; s_in_last = last; s_a = a; s_b = 8'h00;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = s_in_ready;
      @(posedge clock);
    end
    if (!ok) begin
      vec++; bad++;
      $display("FAIL small_accept_timeout: got in_ready 0 expected 1");
    end
    #1 s_in_valid = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (exp_d.size() == 0 && !out_valid) break;
    end
    chk("drain", 64'(exp_d.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_data"}, 64'(data_result), 64'd0);
    chk({tag, "_flags"}, 64'({out_zero, out_ones, out_parity}), 64'b100);
    chk({tag, "_beats"}, 64'(out_beats), 64'd0);
  endtask

  logic [W-1:0] sweep_lit [8] = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h000F_ED00,
                                  32'hFF0F_FFCB, 32'h00FF_ED34, 32'hF000_1200, 32'hF0FF_FF34};

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int t0;
    int lat;
    reset_n = 0; in_valid = 0; in_op = 0; in_accum = 0; in_last = 0;
    data_operandA = '0; data_operandB = '0; out_ready = 1;
    s_in_valid = 0; s_in_op = 0; s_in_accum = 0; s_in_last = 0; s_a = 0; s_b = 0; s_out_ready = 1;
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock);
    #1 reset_n = 1;

    // Latency from drive to out_valid on an idle pipe
    in_valid = 1; in_op = 3'd2; in_accum = 0; in_last = 0;
    data_operandA = 32'h5; data_operandB = 32'h3;
    @(posedge clock);
    model_accept(3'd2, 0, 0, 32'h5, 32'h3);
    #1 in_valid = 0;
    for (lat = 1; lat < 10; lat++) begin
      @(negedge clock);
      if (out_valid) break;
      @(posedge clock);
    end
    chk("latency", 64'(lat), 64'd2);
    wait_drain();

    got_d.delete(); got_b.delete(); got_z.delete(); got_p.delete();
    t0 = cyc;
    for (int op = 0; op < 8; op++) send(3'(op), 0, 0, 32'hF0F0_1234, 32'h0FF0_00FF);
    chk("sweep_throughput", 64'(cyc - t0), 64'd8);
    wait_drain();
    chk("sweep_count", 64'(got_d.size()), 64'd8);
    if (got_d.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("sweep_op%0d", i), 64'(got_d[i]), 64'(sweep_lit[i]));

    got_d.delete(); got_b.delete(); got_z.delete(); got_p.delete();
    send(3'd1, 1, 0, 32'h1, 32'h0);
    send(3'd1, 1, 0, 32'h2, 32'h0);
    send(3'd1, 1, 0, 32'h4, 32'h0);
    send(3'd1, 1, 1, 32'h8, 32'h0);
    wait_drain();
    chk("accum_count", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      chk("accum_data", 64'(got_d[0]), 64'hF);
      chk("accum_beats", 64'(got_b[0]), 64'd4);
      chk("accum_parity", 64'(got_p[0]), 64'd0);
      chk("accum_zero", 64'(got_z[0]), 64'd0);
    end

    got_d.delete(); got_b.delete(); got_z.delete(); got_p.delete();
    send(3'd2, 1, 0, 32'hFF, 32'h0);
    send(3'd0, 0, 0, 32'hFFFF_FFFF, 32'h0);
    send(3'd2, 1, 1, 32'h0F, 32'h0);
    wait_drain();
    chk("interleave_count", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      chk("interleave_pass_data", 64'(got_d[0]), 64'h0);
      chk("interleave_pass_zero", 64'(got_z[0]), 64'd1);
      chk("interleave_pkt_data", 64'(got_d[1]), 64'hF0);
      chk("interleave_pkt_beats", 64'(got_b[1]), 64'd2);
    end

    got_d.delete(); got_b.delete(); got_z.delete(); got_p.delete();
    out_ready = 0;
    send(3'd0, 0, 0, 32'hAAAA_5555, 32'hFFFF_0000);
    send(3'd1, 0, 0, 32'h1, 32'h2);
    in_valid = 1; in_op = 3'd2; in_accum = 0; in_last = 0;
    data_operandA = 32'hF; data_operandB = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(data_result), 64'hAAAA_0000);
      @(posedge clock);
    end
    #1 out_ready = 1;
    send(3'd2, 0, 0, 32'hF, 32'h1);
    wait_drain();
    chk("bp_count", 64'(got_d.size()), 64'd3);
    if (got_d.size() == 3) begin
      chk("bp_first", 64'(got_d[0]), 64'hAAAA_0000);
      chk("bp_second", 64'(got_d[1]), 64'h3);
      chk("bp_third", 64'(got_d[2]), 64'hE);
    end

    send(3'd0, 1, 0, 32'h3, 32'h0);
    send(3'd0, 1, 0, 32'h7, 32'h0);
    reset_n = 0;
    m_open = 0; m_cnt = 0;
    @(negedge clock);
    chk_reset_outputs("midreset");
    @(posedge clock);
    #1 reset_n = 1;
    got_d.delete(); got_b.delete(); got_z.delete(); got_p.delete();
    send(3'd2, 1, 1, 32'h5, 32'h0);
    wait_drain();
    chk("post_reset_count", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      chk("post_reset_data", 64'(got_d[0]), 64'h5);
      chk("post_reset_beats", 64'(got_b[0]), 64'd1);
    end

    s_cnt = 0;
    for (int i = 0; i < 5; i++) send_s(i == 4, 8'hFF);
    repeat (6) @(negedge clock);
    chk("sat_count", 64'(s_cnt), 64'd1);
    chk("sat_data", 64'(s_got), 64'hFF);
    chk("sat_flags", 64'(s_got_f), 64'b010);
    chk("sat_beats", 64'(s_got_b), 64'd3);

    chk("model_empty", 64'(exp_d.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
